// File: rtl/design_ram_n_x_eight_pkg.sv
// Shared constants and types for the 256 x 16 true dual-port RAM.
// Also holds the A-over-B write arbitration helper.
package design_ram_n_x_eight_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    // Port B may commit only when port A is not writing the same word.
    function automatic logic b_wr_allowed(
        input logic  wr_a,
        input logic  wr_b,
        input addr_t addr_a,
        input addr_t addr_b
    );
        return wr_b && !(wr_a && (addr_a == addr_b));
    endfunction

endpackage

// File: rtl/design_ram_port.sv
// One RAM access port: gates the write strobe with reset and
// registers read data, holding it on write cycles.
module design_ram_port
    import design_ram_n_x_eight_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n_i,
    input  logic  we_i,
    input  word_t rdata_i,
    output logic  wr_en_o,
    output word_t dout_o
);

    word_t dout_q;
    word_t dout_d;

    assign wr_en_o = we_i && rst_n_i;

    always_comb begin
        dout_d = dout_q;
        if (!we_i) begin
            dout_d = rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/design_ram_n_x_eight.sv
// True dual-port synchronous RAM, 256 x 16, registered read data.
// Reads return pre-write contents; on a same-address write race A wins.
module design_ram_n_x_eight
    import design_ram_n_x_eight_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] dataout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] dataout_b
);

    word_t mem_q [DEPTH];

    logic  wr_a;
    logic  wr_b;
    logic  wr_b_ok;
    word_t rd_a;
    word_t rd_b;

    assign rd_a    = mem_q[addr_a];
    assign rd_b    = mem_q[addr_b];
    assign wr_b_ok = b_wr_allowed(wr_a, wr_b, addr_a, addr_b);

    design_ram_port u_port_a (
        .clk     (clk),
        .rst_n_i (rst),
        .we_i    (we_a),
        .rdata_i (rd_a),
        .wr_en_o (wr_a),
        .dout_o  (dataout_a)
    );

    design_ram_port u_port_b (
        .clk     (clk),
        .rst_n_i (rst),
        .we_i    (we_b),
        .rdata_i (rd_b),
        .wr_en_o (wr_b),
        .dout_o  (dataout_b)
    );

    // Storage is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem_q[addr_a] <= data_a;
        end
        if (wr_b_ok) begin
            mem_q[addr_b] <= data_b;
        end
    end

endmodule

// File: tb/tb_design_ram_n_x_eight.sv
// Directed self-checking bench for design_ram_n_x_eight.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_design_ram_n_x_eight;

    logic        clk;
    logic        rst;
    logic        we_a;
    logic [7:0]  addr_a;
    logic [15:0] data_a;
    logic [15:0] dataout_a;
    logic        we_b;
    logic [7:0]  addr_b;
    logic [15:0] data_b;
    logic [15:0] dataout_b;

    int n_pass;
    int n_tot;

    design_ram_n_x_eight dut (
        .clk       (clk),
        .rst       (rst),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .data_a    (data_a),
        .dataout_a (dataout_a),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .dataout_b (dataout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tot++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic port_a(input logic we, input logic [7:0] a,
                          input logic [15:0] d);
        we_a = we; addr_a = a; data_a = d;
    endtask

    task automatic port_b(input logic we, input logic [7:0] a,
                          input logic [15:0] d);
        we_b = we; addr_b = a; data_b = d;
    endtask

    logic [15:0] pat [4];

    initial begin
        n_pass = 0;
        n_tot  = 0;
        pat[0] = 16'h0000; pat[1] = 16'h0014;
        pat[2] = 16'h0028; pat[3] = 16'h003C;
        rst = 1'b0;
        port_a(1'b0, 8'd0, 16'h0);
        port_b(1'b0, 8'd0, 16'h0);
        step();
        step();
        chk("reset_a", dataout_a, 16'h0000);
        chk("reset_b", dataout_b, 16'h0000);

        // write via A
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            port_a(1'b1, 8'(2 * i), pat[i]);
            step();
        end
        port_a(1'b0, 8'd0, 16'h0);
        rst = 1'b0;
        step();
        chk("rst_mid_a", dataout_a, 16'h0000);
        chk("rst_mid_b", dataout_b, 16'h0000);
        rst = 1'b1;
        port_a(1'b0, 8'd4, 16'h0);
        step();
        chk("survive_rst", dataout_a, 16'h0028);

        // write via B, read via A
        for (int i = 0; i < 4; i++) begin
            port_b(1'b1, 8'(2 * i), pat[i]);
            step();
        end
        port_b(1'b1, 8'd10, 16'h1234);
        step();
        port_b(1'b0, 8'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            port_a(1'b0, 8'(2 * i), 16'h0);
            step();
            chk($sformatf("rdA_%0d", 2 * i), dataout_a, pat[i]);
        end
        port_a(1'b0, 8'd10, 16'h0);
        step();
        chk("b_wr_a_rd10", dataout_a, 16'h1234);
        port_a(1'b0, 8'd6, 16'h0);
        step();

        // read via B
        for (int i = 0; i < 4; i++) begin
            port_b(1'b0, 8'(2 * i), 16'h0);
            step();
            chk($sformatf("rdB_%0d", 2 * i), dataout_b, pat[i]);
        end
        chk("a_unaffected", dataout_a, 16'h003C);

        // simultaneous read/write
        port_a(1'b1, 8'd9, 16'h005A);
        port_b(1'b0, 8'd6, 16'h0);
        step();
        chk("sim_rdB6", dataout_b, 16'h003C);
        chk("sim_a_hold", dataout_a, 16'h003C);
        port_a(1'b0, 8'd9, 16'h0);
        port_b(1'b1, 8'd8, 16'h0050);
        step();
        chk("sim_rdA9", dataout_a, 16'h005A);
        chk("sim_b_hold", dataout_b, 16'h003C);
        port_b(1'b0, 8'd8, 16'h0);
        step();
        chk("sim_rdB8", dataout_b, 16'h0050);

        // read-during-write
        port_a(1'b1, 8'd3, 16'h1111);
        step();
        port_a(1'b1, 8'd3, 16'h2222);
        port_b(1'b0, 8'd3, 16'h0);
        step();
        chk("rdw_old", dataout_b, 16'h1111);
        port_a(1'b0, 8'd3, 16'h0);
        step();
        chk("rdw_new_b", dataout_b, 16'h2222);
        chk("rdw_new_a", dataout_a, 16'h2222);

        // write-write collision; disjoint dual write
        port_a(1'b1, 8'd5, 16'hAAAA);
        port_b(1'b1, 8'd5, 16'hBBBB);
        step();
        port_a(1'b1, 8'd11, 16'h0B0B);
        port_b(1'b1, 8'd12, 16'h0C0C);
        step();
        port_a(1'b0, 8'd5, 16'h0);
        port_b(1'b0, 8'd5, 16'h0);
        step();
        chk("ww_a", dataout_a, 16'hAAAA);
        chk("ww_b", dataout_b, 16'hAAAA);
        port_a(1'b0, 8'd11, 16'h0);
        port_b(1'b0, 8'd12, 16'h0);
        step();
        chk("dual_wr_a", dataout_a, 16'h0B0B);
        chk("dual_wr_b", dataout_b, 16'h0C0C);

        // address extremes
        port_a(1'b1, 8'd255, 16'hFFFF);
        port_b(1'b1, 8'd0, 16'h8001);
        step();
        port_a(1'b0, 8'd0, 16'h0);
        port_b(1'b0, 8'd255, 16'h0);
        step();
        chk("edge_a0", dataout_a, 16'h8001);
        chk("edge_b255", dataout_b, 16'hFFFF);

        // writes during reset are lost
        port_b(1'b1, 8'd7, 16'h0707);
        step();
        rst = 1'b0;
        port_a(1'b1, 8'd5, 16'h5555);
        port_b(1'b1, 8'd7, 16'h7777);
        step();
        chk("rst_wr_a", dataout_a, 16'h0000);
        chk("rst_wr_b", dataout_b, 16'h0000);
        rst = 1'b1;
        port_a(1'b0, 8'd5, 16'h0);
        port_b(1'b0, 8'd7, 16'h0);
        step();
        chk("rst_lost_a", dataout_a, 16'hAAAA);
        chk("rst_lost_b", dataout_b, 16'h0707);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
